mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one sp_ram req/gnt/rvalid port between two masters, e.g. zeroriscy instr (m0) and data (m1) ports on one unified memory.
// - Round-robin grant; combinational request pass-through; in-order routing of rvalid/rdata via an owner-ID FIFO.
// - Sits between core and memory in unified-memory SoC variants.
// PARAMETERS
// - ADDR_WIDTH  32  address width, all ports
// - DATA_WIDTH  32  data width; BE width = DATA_WIDTH/8
// - OUT_DEPTH   2   max outstanding granted-not-returned transactions; power of 2, >=2
// PORTS
// - clk_i           in   1    clock
// - rst_ni          in   1    synchronous reset, active-low
// - mN_req_i        in   1    master N request, N=0,1; held until granted
// - mN_gnt_o        out  1    master N accepted this cycle
// - mN_rvalid_o     out  1    master N response valid (reads and writes)
// - mN_addr_i       in   AW   master N address
// - mN_we_i         in   1    master N write enable
// - mN_be_i         in   DW/8 master N byte enables
// - mN_wdata_i      in   DW   master N write data
// - mN_rdata_o      out  DW   master N read data; valid with mN_rvalid_o
// - s_req_o/s_gnt_i/s_rvalid_i  out/in/in  1  memory-side handshake
// - s_addr_o, s_we_o, s_be_o, s_wdata_o  out  AW/1/DW/8/DW  muxed from selected master
// - s_rdata_i       in   DW   memory read data
// - err_o           out  1    sticky: s_rvalid_i seen with FIFO empty
// BEHAVIOUR
// - Reset (rst_ni=0 at clk edge): FIFO empty (rd/wr ptr=0, count=0), last_winner=1 (m0 wins first tie), err_o=0, perf counters=0.
// - All outputs combinational from state and inputs; no bubble. sel = winner among requesters.
// - Round-robin: one requester wins; both requesting -> master != last_winner wins.
// - last_winner updates only on an accepted transfer (s_req_o & s_gnt_i).
// - s_req_o = (m0_req_i | m1_req_i) & ~full. full: count==OUT_DEPTH. Pop in the same cycle does NOT lift full (no rvalid->req path).
// - s_addr/we/be/wdata_o = fields of sel; when s_req_o=0 they hold m0 fields.
// - mN_gnt_o = s_gnt_i & s_req_o & (sel==N); never both masters granted in one cycle.
// - Accept: push sel into FIFO at clk edge.
// - s_rvalid_i with count>0: pop head; route to mN_rvalid_o for N=head; s_rdata_i to both mN_rdata_o, valid only with rvalid.
// - Simultaneous push+pop: count unchanged, both pointers advance; wraps mod OUT_DEPTH.
// - s_rvalid_i with count==0: no master rvalid, pointers unchanged, err_o<=1 until reset.
// - Latency: grant 0 cycles after req if memory grants; response follows memory (1 cycle for sp_ram).
// - Reset mid-operation: in-flight ownership discarded; post-reset stray rvalid sets err_o.
// - Master dropping req before gnt: allowed, no state change.
// CONFIGURATION
// - MEM_ARB_PERF_EN defined: extra outputs m0_stall_cnt_o, m1_stall_cnt_o (32b).
//   - Increment each cycle mN_req_i=1 & mN_gnt_o=0; saturate at 32'hFFFF_FFFF; reset to 0.
// - MEM_ARB_PERF_EN undefined: ports and counters absent; arbitration identical.
// TESTING
// - m0 req alone, sp_ram-like slave (gnt same cycle, rvalid +1), read 0x100 -> m0_gnt_o cycle 0; m0_rvalid_o cycle 1 with rdata; m1 silent.
// - Both req every cycle, 8 cycles -> grants alternate m0,m1,m0,... (4 each); each rvalid to matching master in order.
// - Slave rvalid delayed 3 cycles, OUT_DEPTH=2, both requesting -> 2 grants, then s_req_o=0 until first rvalid pop, next cycle re-requests.
// - m1 write 0xDEADBEEF, be=4'b0011 to 0x40 -> s_we_o=1, s_be_o=0011, s_wdata_o=DEADBEEF; m1_rvalid_o next cycle.
// - Stray s_rvalid_i after reset with no request -> err_o=1, both mN_rvalid_o=0; err_o cleared only by rst_ni=0.
// - MEM_ARB_PERF_EN: both req 6 cycles, alternating grants -> m0/m1_stall_cnt_o=3 each; preload 32'hFFFF_FFFE, 3 stalls -> FFFF_FFFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one sp_ram-style req/gnt/rvalid port between two masters
//   (e.g. an instruction fetch port m0 and a data port m1 on a unified memory).
//   Round-robin grant, combinational request pass-through (no bubble), and
//   in-order routing of responses through a small owner-ID FIFO.
//
// Parameters
//   ADDR_WIDTH : address width on all ports
//   DATA_WIDTH : data width; byte-enable width is DATA_WIDTH/8
//   OUT_DEPTH  : max outstanding granted-but-not-returned transactions
//                (power of two, >= 2)
//
// Ports
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   mN_req_i / mN_gnt_o      : master N request / accepted this cycle
//   mN_addr_i, mN_we_i,
//   mN_be_i, mN_wdata_i      : master N request fields
//   mN_rvalid_o, mN_rdata_o  : master N response (reads and writes)
//   s_req_o / s_gnt_i        : memory-side request handshake
//   s_addr_o .. s_wdata_o    : request fields of the selected master
//   s_rvalid_i, s_rdata_i    : memory-side response
//   err_o                    : sticky, response seen with nothing outstanding
//
// Optional feature
//   MEM_ARB_PERF_EN : adds m0_stall_cnt_o / m1_stall_cnt_o, saturating
//                     32-bit counts of cycles a master requested but was
//                     not granted.
// ---------------------------------------------------------------------------

`ifdef MEM_ARB_PERF_EN
// Per-master stall counter: saturates instead of wrapping so a long run
// never reports a misleadingly small number.
module mem_arb_stall_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_stall,
  output logic [31:0] o_cnt
);
  logic [31:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                        r_cnt <= '0;
    else if (i_stall && (r_cnt != '1))  r_cnt <= r_cnt + 32'd1;
  end

  assign o_cnt = r_cnt;
endmodule
`endif

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // master 0
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  // master 1
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  // memory side
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             m0_stall_cnt_o,
  output logic [31:0]             m1_stall_cnt_o
`endif
);

  localparam int NUM_M = 2;
  localparam int BEW   = DATA_WIDTH / 8;
  localparam int PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW    = $clog2(OUT_DEPTH + 1);

  // master fields gathered into packed arrays so selection is a plain index
  logic [NUM_M-1:0]                 w_req;
  logic [NUM_M-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NUM_M-1:0]                 w_we;
  logic [NUM_M-1:0][BEW-1:0]        w_be;
  logic [NUM_M-1:0][DATA_WIDTH-1:0] w_wdata;
  logic [NUM_M-1:0]                 w_gnt;
  logic [NUM_M-1:0]                 w_rvalid;

  assign w_req   = {m1_req_i,   m0_req_i};
  assign w_addr  = {m1_addr_i,  m0_addr_i};
  assign w_we    = {m1_we_i,    m0_we_i};
  assign w_be    = {m1_be_i,    m0_be_i};
  assign w_wdata = {m1_wdata_i, m0_wdata_i};

  // state
  logic [OUT_DEPTH-1:0] r_owner;        // owner ID per outstanding slot
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_last_winner;
  logic                 r_err;

  // arbitration
  logic w_sel;
  logic w_full;
  logic w_accept;
  logic w_pop;
  logic w_head;
  logic w_stray;

  // Tie goes to the master that did not win last; a lone requester always wins.
  always_comb begin
    w_sel = 1'b0;
    if (w_req[0] && w_req[1]) w_sel = ~r_last_winner;
    else if (w_req[1])        w_sel = 1'b1;
  end

  // Full is evaluated on the registered count only: a pop in the same cycle
  // does not reopen the request path, so s_rvalid_i never feeds s_req_o.
  assign w_full   = (r_count == CW'(OUT_DEPTH));
  assign s_req_o  = (|w_req) & ~w_full;
  assign w_accept = s_req_o & s_gnt_i;

  // Request fields follow the winner while requesting, otherwise park on m0.
  always_comb begin
    s_addr_o  = w_addr[0];
    s_we_o    = w_we[0];
    s_be_o    = w_be[0];
    s_wdata_o = w_wdata[0];
    if (s_req_o && w_sel) begin
      s_addr_o  = w_addr[1];
      s_we_o    = w_we[1];
      s_be_o    = w_be[1];
      s_wdata_o = w_wdata[1];
    end
  end

  // response routing
  assign w_head  = r_owner[r_rd_ptr];
  assign w_pop   = s_rvalid_i & (r_count != '0);
  assign w_stray = s_rvalid_i & (r_count == '0);

  genvar g;
  generate
    for (g = 0; g < NUM_M; g++) begin : g_mst
      assign w_gnt[g]    = w_accept & (w_sel == 1'(g));
      assign w_rvalid[g] = w_pop & (w_head == 1'(g));
    end
  endgenerate

  assign m0_gnt_o    = w_gnt[0];
  assign m1_gnt_o    = w_gnt[1];
  assign m0_rvalid_o = w_rvalid[0];
  assign m1_rvalid_o = w_rvalid[1];
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = r_err;

  // owner FIFO contents need no reset: pointers/count define what is live
  always_ff @(posedge clk_i) begin
    if (w_accept) r_owner[r_wr_ptr] <= w_sel;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_last_winner <= 1'b1;   // m0 wins the first tie
      r_err         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr      <= r_wr_ptr + PW'(1);
        r_last_winner <= w_sel;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_stray) r_err <= 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [NUM_M-1:0][31:0] w_stall_cnt;

  generate
    for (g = 0; g < NUM_M; g++) begin : g_perf
      mem_arb_stall_cnt u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_stall (w_req[g] & ~w_gnt[g]),
        .o_cnt   (w_stall_cnt[g])
      );
    end
  endgenerate

  assign m0_stall_cnt_o = w_stall_cnt[0];
  assign m1_stall_cnt_o = w_stall_cnt[1];
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized
// phase, all checked against a queue-based reference model of the arbiter
// and a simple in-order memory slave model.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_req, m1_req, m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic          m0_we, m1_we, s_we;
  logic [BW-1:0] m0_be, m1_be, s_be;
  logic [DW-1:0] m0_wd, m1_wd, s_wd, m0_rd, m1_rd, s_rdata;
  logic          s_req, s_gnt, s_rvalid, err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   st0, st1;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_addr_i(m0_addr),
    .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wd), .m0_rdata_o(m0_rd),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_addr_i(m1_addr),
    .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wd), .m1_rdata_o(m1_rd),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_addr_o(s_addr),
    .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wd), .s_rdata_i(s_rdata),
    .err_o(err)
`ifdef MEM_ARB_PERF_EN
    , .m0_stall_cnt_o(st0), .m1_stall_cnt_o(st1)
`endif
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // reference model: arbiter state as a queue of owners
  bit          q_own[$];
  bit          mdl_last;
  bit          mdl_err;
  logic [31:0] pc0, pc1;
  // slave model: in-order responses, due cycle + data
  int          s_due[$];
  logic [31:0] s_dat[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] last_push_dat;
  // captured DUT outputs of the last tick
  logic        got_g0, got_g1, got_rv0, got_rv1, got_sreq;
  logic [31:0] got_rd0, got_rd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive slave response, check comb outputs, advance model.
  task automatic tick(input bit stray, input bit ce);
    bit any, full, win, acc, pop, own, hit, was_empty;
    int due;
    @(negedge clk);
    hit      = (s_due.size() > 0) && (s_due[0] == cyc);
    s_rvalid = stray | hit;
    s_rdata  = hit ? s_dat[0] : $urandom;
    #1;
    any  = m0_req | m1_req;
    full = (q_own.size() == DEPTH);
    win  = (m0_req && m1_req) ? !mdl_last : m1_req;
    acc  = any && !full && s_gnt;
    pop  = s_rvalid && (q_own.size() > 0);
    own  = pop ? q_own[0] : 1'b0;
    got_g0 = m0_gnt; got_g1 = m1_gnt; got_rv0 = m0_rv; got_rv1 = m1_rv;
    got_sreq = s_req; got_rd0 = m0_rd; got_rd1 = m1_rd;
    if (ce) begin
      chk("s_req",  s_req,  any && !full);
      chk("m0_gnt", m0_gnt, acc && !win);
      chk("m1_gnt", m1_gnt, acc && win);
      chk("m0_rv",  m0_rv,  pop && !own);
      chk("m1_rv",  m1_rv,  pop && own);
      chk("s_addr", s_addr, (any && !full && win) ? m1_addr : m0_addr);
      chk("s_we",   s_we,   (any && !full && win) ? m1_we   : m0_we);
      chk("s_be",   s_be,   (any && !full && win) ? m1_be   : m0_be);
      chk("s_wd",   s_wd,   (any && !full && win) ? m1_wd   : m0_wd);
      chk("m0_rd",  m0_rd,  s_rdata);
      chk("m1_rd",  m1_rd,  s_rdata);
      chk("err",    err,    mdl_err);
`ifdef MEM_ARB_PERF_EN
      chk("st0", st0, pc0);
      chk("st1", st1, pc1);
`endif
    end
    @(posedge clk);
    if (!rst_n) begin
      q_own.delete(); s_due.delete(); s_dat.delete();
      mdl_last = 1'b1; mdl_err = 1'b0; pc0 = '0; pc1 = '0;
    end else begin
      was_empty = (q_own.size() == 0);
      if (pop) void'(q_own.pop_front());
      if (s_rvalid && was_empty) mdl_err = 1'b1;
      if (acc) begin q_own.push_back(win); mdl_last = win; end
      if (m0_req && !(acc && !win) && pc0 != 32'hFFFF_FFFF) pc0++;
      if (m1_req && !(acc && win)  && pc1 != 32'hFFFF_FFFF) pc1++;
      if (hit) begin void'(s_due.pop_front()); void'(s_dat.pop_front()); end
      if (acc) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (s_due.size() > 0 && due <= s_due[$]) due = s_due[$] + 1;
        last_push_dat = $urandom;
        s_due.push_back(due);
        s_dat.push_back(last_push_dat);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; s_gnt = 0;
  endtask

  task automatic do_reset(input bit ce);
    idle();
    rst_n = 0;
    tick(0, ce);
    rst_n = 1;
  endtask

  int g0n, g1n;

  initial begin
    rst_n = 0; idle(); s_rvalid = 0; s_rdata = '0;
    m0_addr = '0; m0_we = 0; m0_be = '0; m0_wd = '0;
    m1_addr = '0; m1_we = 0; m1_be = '0; m1_wd = '0;
    pc0 = '0; pc1 = '0; mdl_last = 1; mdl_err = 0;
    do_reset(0);
    do_reset(0);

    // reset state: idle, no error; tie goes to m0
    chk("rst_err", err, 0);
    chk("rst_sreq", s_req, 0);
    m0_req = 1; m1_req = 1; m0_addr = 32'h11; m1_addr = 32'h22; s_gnt = 0;
    tick(0, 1);
    chk("rst_tie_sel_m0", got_sreq, 1);
    do_reset(1);

    // m0 single read, sp_ram-like slave
    lat_min = 1; lat_max = 1;
    m0_req = 1; m0_addr = 32'h100; m0_we = 0; m0_be = 4'hF; s_gnt = 1;
    tick(0, 1);
    chk("rd_gnt0", got_g0, 1);
    chk("rd_gnt1", got_g1, 0);
    m0_req = 0;
    tick(0, 1);
    chk("rd_rv0", got_rv0, 1);
    chk("rd_rv1", got_rv1, 0);
    chk("rd_data", got_rd0, last_push_dat);

    // both request for 8 cycles: strict alternation starting with m0
    do_reset(1);
    g0n = 0; g1n = 0;
    m0_req = 1; m1_req = 1; s_gnt = 1;
    for (int i = 0; i < 8; i++) begin
      m0_addr = $urandom; m1_addr = $urandom;
      tick(0, 1);
      chk("alt_g0", got_g0, (i % 2) == 0);
      chk("alt_g1", got_g1, (i % 2) == 1);
      if (i > 0) chk("alt_rv_owner", got_rv1, (i % 2) == 0);
      g0n += int'(got_g0); g1n += int'(got_g1);
`ifdef MEM_ARB_PERF_EN
      if (i == 5) begin chk("perf_st0_6", st0, 3); chk("perf_st1_6", st1, 3); end
`endif
    end
    chk("alt_cnt0", g0n, 4);
    chk("alt_cnt1", g1n, 4);
    idle(); tick(0, 1); tick(0, 1);

    // slow slave: fills to OUT_DEPTH, request stays low through the pop cycle
    do_reset(1);
    lat_min = 3; lat_max = 3;
    m0_req = 1; m1_req = 1; s_gnt = 1;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1);
      if (i == 0) chk("full_g0", got_g0, 1);
      if (i == 1) chk("full_g1", got_g1, 1);
      if (i == 2) chk("full_sreq_c2", got_sreq, 0);
      if (i == 3) begin chk("full_sreq_pop", got_sreq, 0); chk("full_rv0", got_rv0, 1); end
      if (i == 4) chk("full_sreq_c4", got_sreq, 1);
    end
    idle();
    for (int i = 0; i < 6; i++) tick(0, 1);

    // m1 write
    do_reset(1);
    lat_min = 1; lat_max = 1;
    m0_addr = 32'h5555; m1_req = 1; m1_addr = 32'h40; m1_we = 1;
    m1_be = 4'b0011; m1_wd = 32'hDEADBEEF; s_gnt = 1;
    tick(0, 1);
    chk("wr_gnt1", got_g1, 1);
    chk("wr_addr", s_addr, 32'h40);
    chk("wr_we", s_we, 1);
    chk("wr_be", s_be, 4'b0011);
    chk("wr_wd", s_wd, 32'hDEADBEEF);
    idle();
    tick(0, 1);
    chk("wr_rv1", got_rv1, 1);
    m1_we = 0;

    // stray response after reset
    do_reset(1);
    tick(1, 1);
    chk("stray_rv0", got_rv0, 0);
    chk("stray_rv1", got_rv1, 0);
    chk("stray_err", err, 1);
    for (int i = 0; i < 3; i++) tick(0, 1);
    chk("stray_err_sticky", err, 1);
    do_reset(1);
    chk("stray_err_clr", err, 0);

    // reset with a transaction in flight, then a late response is stray
    lat_min = 3; lat_max = 3;
    m0_req = 1; s_gnt = 1;
    tick(0, 1);
    do_reset(1);
    tick(1, 1);
    chk("midrst_rv0", got_rv0, 0);
    chk("midrst_err", err, 1);

    // randomized traffic, variable slave latency
    do_reset(1);
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      m0_req = ($urandom % 3) != 0;  m1_req = ($urandom % 3) != 0;
      m0_addr = $urandom; m0_we = $urandom; m0_be = $urandom; m0_wd = $urandom;
      m1_addr = $urandom; m1_we = $urandom; m1_be = $urandom; m1_wd = $urandom;
      s_gnt = ($urandom % 4) != 0;
      if (i == 200) begin do_reset(1); end
      else tick(0, 1);
    end
    idle();
    for (int i = 0; i < 10; i++) tick(0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
